// File: rtl/triple_demux_buffer_if.sv
// Handshake and data bundle for triple_demux_buffer: one input triple stream,
// two steered output channels with occupancy counts.
interface triple_demux_buffer_if #(
   parameter int AW = 1
);
   logic          InValid;
   logic          InReady;
   logic          InSel;
   logic [31:0]   In1;
   logic [31:0]   In2;
   logic [31:0]   In3;
   logic          OutAValid;
   logic          OutAReady;
   logic [31:0]   OutA1;
   logic [31:0]   OutA2;
   logic [31:0]   OutA3;
   logic          OutBValid;
   logic          OutBReady;
   logic [31:0]   OutB1;
   logic [31:0]   OutB2;
   logic [31:0]   OutB3;
   logic [AW:0]   CountA;
   logic [AW:0]   CountB;

   modport master (
      output InValid, InSel, In1, In2, In3, OutAReady, OutBReady,
      input  InReady, OutAValid, OutA1, OutA2, OutA3,
             OutBValid, OutB1, OutB2, OutB3, CountA, CountB
   );

   modport slave (
      input  InValid, InSel, In1, In2, In3, OutAReady, OutBReady,
      output InReady, OutAValid, OutA1, OutA2, OutA3,
             OutBValid, OutB1, OutB2, OutB3, CountA, CountB
   );
endinterface

// File: rtl/triple_demux_buffer.sv
// Steers a stream of 32-bit word triples into one of two independent FIFO
// channels (A when InSel=1, B otherwise), each with its own valid/ready output.
module triple_demux_buffer #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic                  Clk,
   input  logic                  Rst,
   triple_demux_buffer_if.slave  bus
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [95:0]   mem_a [DEPTH];
   logic [95:0]   mem_b [DEPTH];
   logic [AW-1:0] wptr_a, rptr_a, wptr_b, rptr_b;
   logic [AW:0]   cnt_a, cnt_b;
   logic          full_a, full_b, valid_a, valid_b;
   logic          in_ready, push_a, push_b, pop_a, pop_b;
   logic [95:0]   head_a, head_b;

   assign full_a  = (cnt_a == FULL_CNT);
   assign full_b  = (cnt_b == FULL_CNT);
   assign valid_a = (cnt_a != '0);
   assign valid_b = (cnt_b != '0);

   // Ready looks only at occupancy, so a pop never frees a slot for the same edge.
   assign in_ready = !Rst && (bus.InSel ? !full_a : !full_b);
   assign push_a   = bus.InValid && in_ready && bus.InSel;
   assign push_b   = bus.InValid && in_ready && !bus.InSel;
   assign pop_a    = valid_a && bus.OutAReady;
   assign pop_b    = valid_b && bus.OutBReady;

   always_ff @(posedge Clk) begin
      if (push_a) mem_a[wptr_a] <= {bus.In1, bus.In2, bus.In3};
      if (push_b) mem_b[wptr_b] <= {bus.In1, bus.In2, bus.In3};
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wptr_a <= '0;
         rptr_a <= '0;
         cnt_a  <= '0;
         wptr_b <= '0;
         rptr_b <= '0;
         cnt_b  <= '0;
      end else begin
         if (push_a) wptr_a <= wptr_a + AW'(1);
         if (pop_a)  rptr_a <= rptr_a + AW'(1);
         if (push_b) wptr_b <= wptr_b + AW'(1);
         if (pop_b)  rptr_b <= rptr_b + AW'(1);
         case ({push_a, pop_a})
            2'b10:   cnt_a <= cnt_a + (AW+1)'(1);
            2'b01:   cnt_a <= cnt_a - (AW+1)'(1);
            default: cnt_a <= cnt_a;
         endcase
         case ({push_b, pop_b})
            2'b10:   cnt_b <= cnt_b + (AW+1)'(1);
            2'b01:   cnt_b <= cnt_b - (AW+1)'(1);
            default: cnt_b <= cnt_b;
         endcase
      end
   end

   // Head words are masked to zero whenever the channel is empty.
   always_comb begin
      head_a = '0;
      head_b = '0;
      if (valid_a) head_a = mem_a[rptr_a];
      if (valid_b) head_b = mem_b[rptr_b];
   end

   assign bus.InReady   = in_ready;
   assign bus.OutAValid = valid_a;
   assign bus.OutA1     = head_a[95:64];
   assign bus.OutA2     = head_a[63:32];
   assign bus.OutA3     = head_a[31:0];
   assign bus.OutBValid = valid_b;
   assign bus.OutB1     = head_b[95:64];
   assign bus.OutB2     = head_b[63:32];
   assign bus.OutB3     = head_b[31:0];
   assign bus.CountA    = cnt_a;
   assign bus.CountB    = cnt_b;

endmodule

// File: tb/tb_triple_demux_buffer.sv
// Bench for triple_demux_buffer: queue-based channel model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_triple_demux_buffer;

   localparam int DEPTH = 2;
   localparam int AW    = 1;

   logic Clk = 1'b0;
   logic Rst = 1'b1;

   triple_demux_buffer_if #(.AW(AW)) bus ();

   triple_demux_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int passes = 0;
   logic [95:0] qa[$];
   logic [95:0] qb[$];
   logic [95:0] exp_ha, exp_hb;
   logic        exp_rdy, acc;
   bit          started = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: each channel is a plain bounded queue.
   always @(posedge Clk) begin
      started <= 1'b1;
      if (Rst) begin
         qa.delete();
         qb.delete();
      end else begin
         acc = bus.InValid && (bus.InSel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
         if (bus.OutAReady && qa.size() > 0) void'(qa.pop_front());
         if (bus.OutBReady && qb.size() > 0) void'(qb.pop_front());
         if (acc) begin
            if (bus.InSel) qa.push_back({bus.In1, bus.In2, bus.In3});
            else           qb.push_back({bus.In1, bus.In2, bus.In3});
         end
      end
   end

   always @(negedge Clk) begin
      if (started) begin
         exp_ha  = (qa.size() > 0) ? qa[0] : '0;
         exp_hb  = (qb.size() > 0) ? qb[0] : '0;
         exp_rdy = !Rst && (bus.InSel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
         chk("in_ready", bus.InReady, exp_rdy);
         chk("a_valid", bus.OutAValid, qa.size() != 0);
         chk("b_valid", bus.OutBValid, qb.size() != 0);
         chk("count_a", bus.CountA, qa.size());
         chk("count_b", bus.CountB, qb.size());
         chk("a_head", {bus.OutA1, bus.OutA2, bus.OutA3}, exp_ha);
         chk("b_head", {bus.OutB1, bus.OutB2, bus.OutB3}, exp_hb);
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sel,
                        input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
      bus.InValid = v;
      bus.InSel   = sel;
      bus.In1     = w1;
      bus.In2     = w2;
      bus.In3     = w3;
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, '0, '0);
      bus.OutAReady = 1'b0;
      bus.OutBReady = 1'b0;

      // Reset then idle
      step();
      step();
      Rst = 1'b0;
      #1;
      chk("rst_count_a", bus.CountA, 0);
      chk("rst_count_b", bus.CountB, 0);
      chk("rst_valids", {bus.OutAValid, bus.OutBValid}, 0);
      chk("rst_words", {bus.OutA1, bus.OutA2, bus.OutA3, bus.OutB1, bus.OutB2, bus.OutB3}, 0);
      bus.InSel = 1'b1; #1;
      chk("rst_ready_sel1", bus.InReady, 1);
      bus.InSel = 1'b0; #1;
      chk("rst_ready_sel0", bus.InReady, 1);

      // Basic steering
      drive(1'b1, 1'b1, 1, 2, 3); step();
      drive(1'b1, 1'b0, 4, 5, 6); step();
      drive(1'b0, 1'b0, 0, 0, 0); #1;
      chk("steer_count_a", bus.CountA, 1);
      chk("steer_count_b", bus.CountB, 1);
      chk("steer_a", {bus.OutA1, bus.OutA2, bus.OutA3}, {32'd1, 32'd2, 32'd3});
      chk("steer_b", {bus.OutB1, bus.OutB2, bus.OutB3}, {32'd4, 32'd5, 32'd6});
      bus.OutAReady = 1'b1; bus.OutBReady = 1'b1; step();
      bus.OutAReady = 1'b0; bus.OutBReady = 1'b0; #1;
      chk("drain_counts", {bus.CountA, bus.CountB}, 0);

      // Full and backpressure on A
      drive(1'b1, 1'b1, 32'h10, 32'h10, 32'h10); step();
      drive(1'b1, 1'b1, 32'h20, 32'h20, 32'h20); step();
      drive(1'b1, 1'b1, 32'h30, 32'h30, 32'h30); #1;
      chk("full_ready", bus.InReady, 0);
      chk("full_count_a", bus.CountA, 2);
      chk("full_head0", bus.OutA1, 32'h10);
      step();
      chk("full_hold_count", bus.CountA, 2);
      bus.OutAReady = 1'b1; step();
      bus.OutAReady = 1'b0; #1;
      chk("pop_no_push_count", bus.CountA, 1);
      chk("full_head1", bus.OutA1, 32'h20);
      chk("ready_after_pop", bus.InReady, 1);
      step();
      drive(1'b0, 1'b1, 0, 0, 0); #1;
      chk("third_accepted", bus.CountA, 2);

      // Cross-channel independence
      drive(1'b1, 1'b0, 32'hC0, 32'hC1, 32'hC2); #1;
      chk("cross_ready", bus.InReady, 1);
      step();
      drive(1'b0, 1'b0, 0, 0, 0); #1;
      chk("cross_count_b", bus.CountB, 1);
      chk("cross_count_a", bus.CountA, 2);
      chk("cross_head_a", bus.OutA1, 32'h20);
      bus.OutAReady = 1'b1; step();
      chk("order_a_30", bus.OutA1, 32'h30);
      step();
      bus.OutAReady = 1'b0; #1;
      chk("order_a_empty", bus.CountA, 0);

      // Simultaneous push and pop on B
      bus.OutBReady = 1'b1; step();
      bus.OutBReady = 1'b0;
      drive(1'b1, 1'b0, 32'hAA, 32'hAA, 32'hAA); step();
      drive(1'b1, 1'b0, 32'hBB, 32'hBB, 32'hBB);
      bus.OutBReady = 1'b1; #1;
      chk("sim_head_before", bus.OutB1, 32'hAA);
      step();
      drive(1'b0, 1'b0, 0, 0, 0);
      bus.OutBReady = 1'b0; #1;
      chk("sim_count_b", bus.CountB, 1);
      chk("sim_head_after", bus.OutB1, 32'hBB);

      // Reset mid-operation
      drive(1'b1, 1'b1, 32'h51, 32'h51, 32'h51); step();
      drive(1'b1, 1'b1, 32'h52, 32'h52, 32'h52); step();
      drive(1'b1, 1'b0, 32'h61, 32'h61, 32'h61); step();
      #1;
      chk("pre_rst_counts", {bus.CountA, bus.CountB}, {2'd2, 2'd2});
      Rst = 1'b1;
      drive(1'b1, 1'b1, 32'h99, 32'h99, 32'h99);
      bus.OutAReady = 1'b1; bus.OutBReady = 1'b1;
      step();
      Rst = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 0);
      bus.OutAReady = 1'b0; bus.OutBReady = 1'b0; #1;
      chk("mid_rst_counts", {bus.CountA, bus.CountB}, 0);
      chk("mid_rst_valids", {bus.OutAValid, bus.OutBValid}, 0);
      chk("mid_rst_words", {bus.OutA1, bus.OutB1}, 0);
      drive(1'b1, 1'b1, 32'h77, 32'h78, 32'h79); step();
      drive(1'b0, 1'b0, 0, 0, 0); #1;
      chk("post_rst_push", {bus.OutA1, bus.OutA2, bus.OutA3}, {32'h77, 32'h78, 32'h79});
      chk("post_rst_count", bus.CountA, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         Rst = ($urandom_range(63) == 0);
         drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom, $urandom);
         bus.OutAReady = ($urandom_range(3) == 0);
         bus.OutBReady = ($urandom_range(2) != 0);
         step();
      end
      Rst = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 0);
      step();
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
